// File: rtl/cmult_arbiter.sv
// -----------------------------------------------------------------------------
// cmult_arbiter
//   Shares one mult_complex (Q1.15 complex multiplier, fixed 2-cycle latency)
//   among N requesters using round-robin arbitration. Each issued operation is
//   tagged with its requester index. The product comes back two cycles later
//   with a single-cycle result strobe.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_en         arbitration enable; low = no new grants, pipeline drains
//   i_req_valid  [N]      requester k has operands present
//   o_req_ready  [N]      grant to requester k this cycle (one-hot or zero)
//   i_req_ar/ai/br/bi [16*N]  packed signed operands, slice k = requester k
//   o_res_valid  result strobe, one cycle per accepted request
//   o_res_id     [IDW]    requester index of the current result
//   o_res_r/i    [16]     signed product (zero when o_res_valid is low)
//   o_busy       at least one operation in flight
//
// mult_complex
//   Q1.15 x Q1.15 complex multiply. Stage 1 registers the four partial
//   products, each truncated to Q1.15 (bits [30:15]). Stage 2 registers the
//   16-bit wrapping difference/sum. No rounding, no saturation.
//
// Ports
//   i_clk        clock, rising edge
//   i_srst       synchronous active-high reset
//   i_ar/ai/br/bi  signed Q1.15 operands
//   o_cr, o_ci   product, valid two clocks after the operands are presented
// -----------------------------------------------------------------------------

module mult_complex (
  input  logic               i_clk,
  input  logic               i_srst,
  input  logic signed [15:0] i_ar,
  input  logic signed [15:0] i_ai,
  input  logic signed [15:0] i_br,
  input  logic signed [15:0] i_bi,
  output logic signed [15:0] o_cr,
  output logic signed [15:0] o_ci
);

  // Full-precision partial products (Q2.30).
  logic signed [31:0] w_p_rr;
  logic signed [31:0] w_p_ii;
  logic signed [31:0] w_p_ri;
  logic signed [31:0] w_p_ir;

  assign w_p_rr = i_ar * i_br;
  assign w_p_ii = i_ai * i_bi;
  assign w_p_ri = i_ar * i_bi;
  assign w_p_ir = i_ai * i_br;

  // Stage 1: partial products truncated back to Q1.15.
  logic signed [15:0] r_t_rr;
  logic signed [15:0] r_t_ii;
  logic signed [15:0] r_t_ri;
  logic signed [15:0] r_t_ir;

  // Stage 2: combined real/imaginary parts.
  logic signed [15:0] r_cr;
  logic signed [15:0] r_ci;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_t_rr <= '0;
      r_t_ii <= '0;
      r_t_ri <= '0;
      r_t_ir <= '0;
      r_cr   <= '0;
      r_ci   <= '0;
    end else begin
      // Arithmetic shift then keep 16 bits == take bits [30:15].
      r_t_rr <= 16'(w_p_rr >>> 15);
      r_t_ii <= 16'(w_p_ii >>> 15);
      r_t_ri <= 16'(w_p_ri >>> 15);
      r_t_ir <= 16'(w_p_ir >>> 15);
      // 16-bit wrap-around on purpose; no saturation.
      r_cr   <= r_t_rr - r_t_ii;
      r_ci   <= r_t_ri + r_t_ir;
    end
  end

  assign o_cr = r_cr;
  assign o_ci = r_ci;

endmodule

module cmult_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [N-1:0]         i_req_valid,
  output logic [N-1:0]         o_req_ready,
  input  logic [16*N-1:0]      i_req_ar,
  input  logic [16*N-1:0]      i_req_ai,
  input  logic [16*N-1:0]      i_req_br,
  input  logic [16*N-1:0]      i_req_bi,
  output logic                 o_res_valid,
  output logic [IDW-1:0]       o_res_id,
  output logic signed [15:0]   o_res_r,
  output logic signed [15:0]   o_res_i,
  output logic                 o_busy
);

  // Multiplier latency, fixed by mult_complex.
  localparam int LAT = 2;

  // ---------------------------------------------------------------------------
  // Operand unpacking
  // ---------------------------------------------------------------------------
  logic signed [15:0] w_ar [N];
  logic signed [15:0] w_ai [N];
  logic signed [15:0] w_br [N];
  logic signed [15:0] w_bi [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_ar[gi] = i_req_ar[16*gi +: 16];
      assign w_ai[gi] = i_req_ai[16*gi +: 16];
      assign w_br[gi] = i_req_br[16*gi +: 16];
      assign w_bi[gi] = i_req_bi[16*gi +: 16];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin grant
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_grant_id;
  logic           w_found;
  logic           w_hs;

  // Walk from the pointer, wrapping modulo N; first valid requester wins.
  // The index is built one bit wider so N that is not a power of two wraps
  // correctly.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    for (int off = 0; off < N; off++) begin
      logic [IDW:0] v_sum;
      v_sum = {1'b0, r_ptr} + (IDW+1)'(off);
      if (v_sum >= (IDW+1)'(N)) begin
        v_sum = v_sum - (IDW+1)'(N);
      end
      if (!w_found && i_req_valid[v_sum[IDW-1:0]]) begin
        w_found    = 1'b1;
        w_grant_id = v_sum[IDW-1:0];
      end
    end
  end

  // A grant is only given when enabled and out of reset; because ready is
  // derived from a valid requester, ready implies a handshake.
  assign w_hs = w_found & i_en & i_rst_n;

  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign o_req_ready[gi] = w_hs && (w_grant_id == IDW'(gi));
    end
  endgenerate

  // Pointer moves past the granted requester only on a handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      if (w_grant_id == IDW'(N-1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_grant_id + IDW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand mux into the shared multiplier
  // ---------------------------------------------------------------------------
  // Idle cycles feed zeros so requesters that are waiting (or idle) never
  // toggle the multiplier datapath.
  logic signed [15:0] w_mul_ar;
  logic signed [15:0] w_mul_ai;
  logic signed [15:0] w_mul_br;
  logic signed [15:0] w_mul_bi;
  logic signed [15:0] w_cr;
  logic signed [15:0] w_ci;
  logic               w_mul_srst;

  assign w_mul_ar   = w_hs ? w_ar[w_grant_id] : '0;
  assign w_mul_ai   = w_hs ? w_ai[w_grant_id] : '0;
  assign w_mul_br   = w_hs ? w_br[w_grant_id] : '0;
  assign w_mul_bi   = w_hs ? w_bi[w_grant_id] : '0;
  assign w_mul_srst = ~i_rst_n;

  mult_complex u_mult (
    .i_clk  (i_clk),
    .i_srst (w_mul_srst),
    .i_ar   (w_mul_ar),
    .i_ai   (w_mul_ai),
    .i_br   (w_mul_br),
    .i_bi   (w_mul_bi),
    .o_cr   (w_cr),
    .o_ci   (w_ci)
  );

  // ---------------------------------------------------------------------------
  // Tag pipeline: {valid, id} travels alongside the multiplier stages
  // ---------------------------------------------------------------------------
  logic           r_tag_vld [LAT];
  logic [IDW-1:0] r_tag_id  [LAT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < LAT; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_id[s]  <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_hs;
      r_tag_id[0]  <= w_grant_id;
      for (int s = 1; s < LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  logic w_busy;

  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      w_busy = w_busy | r_tag_vld[s];
    end
  end

  // ---------------------------------------------------------------------------
  // Result outputs
  // ---------------------------------------------------------------------------
  // The tag's async reset makes the result disappear as soon as reset is
  // asserted, even though the multiplier itself only clears on a clock edge.
  // Gating also hides stale multiplier contents between results.
  logic w_res_valid;

  assign w_res_valid = r_tag_vld[LAT-1];
  assign o_res_valid = w_res_valid;
  assign o_res_id    = w_res_valid ? r_tag_id[LAT-1] : '0;
  assign o_res_r     = w_res_valid ? w_cr : '0;
  assign o_res_i     = w_res_valid ? w_ci : '0;
  assign o_busy      = w_busy;

endmodule
